// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Used by pc_fetch_ctrl and its one-entry output buffer.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_INC      = 4;

  // Instruction addresses are word aligned; any set low bit makes a bad target.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_out_buf.sv
// One-entry buffer holding the fetched instruction and its address until decode takes it.
// Flush wins over load, and load wins over consume.
module fetch_out_buf
  import pc_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     consume,
  input  logic                     flush,
  input  logic [INSTR_WIDTH-1:0]   load_instr,
  input  logic [ADDRESS_WIDTH-1:0] load_pc,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc
);

  // NOTE: the payload is a single register, not a memory array, so it is reset
  // along with the valid bit; decode then never sees stale X after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (flush) begin
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (load) begin
      instr_valid <= 1'b1;
      instr       <= load_instr;
      instr_pc    <= load_pc;
    end else if (consume) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch sequencer: PC register, redirect adder and fetch FSM.
// Optional misaligned-redirect trap is enabled by defining PC_FETCH_MISALIGN_TRAP_EN.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 12,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_base,
  input  logic [ADDRESS_WIDTH-1:0] redirect_imm,
  input  logic                     stall,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     misalign_trap
);

  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(PC_INC);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] drain_target;
  logic                     req_pending;
  logic [ADDRESS_WIDTH-1:0] raw_target;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     target_bad;
  logic                     ack_fire;
  logic                     buf_load;
  logic                     buf_consume;
  logic                     buf_flush;

  // Adder result is truncated to the address width, so overflow wraps silently.
  assign raw_target = redirect_base + redirect_imm;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign target     = raw_target;
  assign target_bad = is_misaligned(raw_target[1:0]);
`else
  assign target     = raw_target & ALIGN_MASK;
  assign target_bad = 1'b0;
`endif

  assign imem_addr = pc;

  // NOTE: every output of this always_comb gets a value before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    imem_req = 1'b0;
    unique case (state)
      IDLE:  imem_req = 1'b0;
      FETCH: imem_req = req_pending || !instr_valid || !stall;
      DRAIN: imem_req = 1'b1;
      HALT:  imem_req = req_pending;
    endcase
  end

  assign ack_fire    = imem_req && imem_ack;
  assign buf_load    = ack_fire && (state == FETCH) && !redirect_valid;
  assign buf_consume = instr_valid && !stall;
  assign buf_flush   = redirect_valid || (state == HALT);

  // NOTE: state registers use non-blocking assignments so every branch reads the
  // pre-edge values of pc/state regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      drain_target <= RESET_PC;
      req_pending  <= 1'b0;
    end else begin
      req_pending <= imem_req && !imem_ack;
      unique case (state)
        IDLE: begin
          if (redirect_valid && target_bad) begin
            state <= HALT;
          end else begin
            state <= FETCH;
            if (redirect_valid) pc <= target;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            if (target_bad) begin
              state <= HALT;
            end else if (imem_req && !imem_ack) begin
              // Memory still owes us a word; keep the old address until it lands.
              drain_target <= target;
              state        <= DRAIN;
            end else begin
              pc <= target;
            end
          end else if (ack_fire) begin
            pc <= pc + PC_STEP;
          end
        end
        DRAIN: begin
          if (redirect_valid && target_bad) begin
            state <= HALT;
          end else if (imem_ack) begin
            pc    <= redirect_valid ? target : drain_target;
            state <= FETCH;
          end else if (redirect_valid) begin
            drain_target <= target;
          end
        end
        HALT: state <= HALT;
      endcase
    end
  end

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trap_q <= 1'b0;
    end else if (redirect_valid && target_bad) begin
      trap_q <= 1'b1;
    end
  end

  assign misalign_trap = trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

  fetch_out_buf #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_out_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (buf_load),
    .consume    (buf_consume),
    .flush      (buf_flush),
    .load_instr (imem_rdata),
    .load_pc    (pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc)
  );

  // An issued request must hold its address until memory acknowledges it.
  req_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr)));

  // A fill must never overwrite an entry decode has not taken yet.
  no_overwrite_a: assert property (@(posedge clk) disable iff (!rst)
    !(buf_load && instr_valid && stall));

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a transaction-level model checked every cycle,
// plus hand-computed literal expectations at key points of the stimulus.
module tb_pc_fetch_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_base = '0;
  logic [AW-1:0] redirect_imm = '0;
  logic          stall = 1'b0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          misalign_trap;

  pc_fetch_ctrl #(.ADDRESS_WIDTH(AW), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_base (redirect_base),
    .redirect_imm  (redirect_imm),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Memory content: every word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [31:0]   word;
    logic [AW-1:0] pc;
  } entry_t;

  entry_t        m_buf[$];
  bit            m_started = 1'b0;  // first clock after reset has passed
  bit            m_busy    = 1'b0;  // a request is out and not yet acked
  bit            m_drop    = 1'b0;  // that request's data must be thrown away
  bit            m_halt    = 1'b0;
  bit            m_trap    = 1'b0;
  logic [AW-1:0] m_pc      = '0;
  logic [AW-1:0] m_resume  = '0;

  function automatic bit m_req();
    return m_started && (m_busy || (!m_halt && (m_buf.size() == 0 || !stall)));
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_buf.delete();
        m_started = 1'b0; m_busy = 1'b0; m_drop = 1'b0;
        m_halt = 1'b0; m_trap = 1'b0; m_pc = '0; m_resume = '0;
      end else begin
        bit            req;
        bit            fire;
        logic [AW-1:0] tgt;
        req  = m_req();
        fire = req && imem_ack;
        if (!m_started) begin
          m_started = 1'b1;
        end else if (m_halt) begin
          if (fire) m_busy = 1'b0;
        end else begin
          if (m_buf.size() != 0 && !stall) void'(m_buf.pop_front());
          if (redirect_valid) begin
            m_buf.delete();
            tgt = redirect_base + redirect_imm;
            if (TRAP_EN && tgt[1:0] != 2'b00) begin
              m_halt = 1'b1; m_trap = 1'b1; m_drop = 1'b0;
              m_busy = req && !imem_ack;
            end else begin
              tgt[1:0] = 2'b00;
              if (req && !imem_ack) begin
                m_busy = 1'b1; m_drop = 1'b1; m_resume = tgt;
              end else begin
                m_pc = tgt; m_busy = 1'b0; m_drop = 1'b0;
              end
            end
          end else if (fire) begin
            if (m_drop) begin
              m_pc = m_resume; m_drop = 1'b0;
            end else begin
              m_buf.push_back('{word: mem_word(m_pc), pc: m_pc});
              m_pc = m_pc + AW'(4);
            end
            m_busy = 1'b0;
          end else begin
            m_busy = req;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("imem_req", 32'(imem_req), 32'(m_req()));
      check("imem_addr", 32'(imem_addr), 32'(m_pc));
      check("instr_valid", 32'(instr_valid), 32'(m_buf.size() != 0));
      if (m_buf.size() != 0) begin
        check("instr", instr, m_buf[0].word);
        check("instr_pc", 32'(instr_pc), 32'(m_buf[0].pc));
      end
      check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic redirect(input logic [AW-1:0] base, input logic [AW-1:0] imm);
    redirect_valid = 1'b1;
    redirect_base  = base;
    redirect_imm   = imm;
  endtask

  initial begin
    repeat (2) tick();
    #1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", 32'(imem_addr), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", 32'(instr_pc), 0);
    check("rst_trap", 32'(misalign_trap), 0);

    // Zero-wait stream after reset release.
    tick(); rst = 1'b1; imem_ack = 1'b1; stall = 1'b0; #1;
    check("idle_req", 32'(imem_req), 0);
    tick(); #1;
    check("first_req", 32'(imem_req), 1);
    check("first_addr", 32'(imem_addr), 32'h000);
    tick(); #1;
    check("stream_addr4", 32'(imem_addr), 32'h004);
    check("first_valid", 32'(instr_valid), 1);
    check("first_instr", instr, 32'hC0DE_0000);
    check("first_instr_pc", 32'(instr_pc), 32'h000);
    tick(); #1;
    check("stream_addr8", 32'(imem_addr), 32'h008);
    check("stream_pc4", 32'(instr_pc), 32'h004);

    // Decode stall with a full buffer.
    tick(); stall = 1'b1; #1;
    check("stall_addr", 32'(imem_addr), 32'h00C);
    check("stall_req", 32'(imem_req), 0);
    repeat (2) begin
      tick(); #1;
      check("stall_req_hold", 32'(imem_req), 0);
      check("stall_pc_frozen", 32'(instr_pc), 32'h008);
    end
    tick(); stall = 1'b0; #1;
    check("unstall_req", 32'(imem_req), 1);
    check("unstall_addr", 32'(imem_addr), 32'h00C);

    // Ack delayed three cycles at 0x010.
    tick(); imem_ack = 1'b0; #1;
    check("wait_addr", 32'(imem_addr), 32'h010);
    check("wait_pc", 32'(instr_pc), 32'h00C);
    repeat (2) begin
      tick(); #1;
      check("wait_hold_addr", 32'(imem_addr), 32'h010);
      check("wait_hold_req", 32'(imem_req), 1);
    end
    tick(); imem_ack = 1'b1; #1;
    check("wait_ack_addr", 32'(imem_addr), 32'h010);
    tick(); imem_ack = 1'b0; #1;
    check("after_wait_addr", 32'(imem_addr), 32'h014);
    check("after_wait_pc", 32'(instr_pc), 32'h010);

    // Redirect to 0x020-8 while the request at 0x014 is outstanding.
    tick(); redirect(12'h020, 12'hFF8); #1;
    check("drain_old_addr", 32'(imem_addr), 32'h014);
    tick(); redirect_valid = 1'b0; #1;
    check("drain_hold_addr", 32'(imem_addr), 32'h014);
    check("drain_req", 32'(imem_req), 1);
    check("drain_valid", 32'(instr_valid), 0);
    tick(); imem_ack = 1'b1; #1;
    tick(); #1;
    check("drain_target", 32'(imem_addr), 32'h018);
    check("drain_discard", 32'(instr_valid), 0);

    // Redirect coinciding with ack, then PC wrap.
    tick(); redirect(12'h100, 12'h040); #1;
    check("pre_redir_pc", 32'(instr_pc), 32'h018);
    tick(); redirect_valid = 1'b0; #1;
    check("ack_redir_addr", 32'(imem_addr), 32'h140);
    check("ack_redir_drop", 32'(instr_valid), 0);
    tick(); redirect(12'hFF0, 12'h00C); #1;
    tick(); redirect_valid = 1'b0; #1;
    check("wrap_top", 32'(imem_addr), 32'hFFC);
    tick(); redirect(12'hFF0, 12'h020); #1;
    check("wrap_zero", 32'(imem_addr), 32'h000);
    check("wrap_pc", 32'(instr_pc), 32'hFFC);
    tick(); redirect_valid = 1'b0; stall = 1'b1; #1;
    check("adder_wrap", 32'(imem_addr), 32'h010);
    check("empty_req_stalled", 32'(imem_req), 1);

    // Redirect with no request outstanding.
    tick(); redirect(12'h200, 12'h000); #1;
    check("idle_redir_req", 32'(imem_req), 0);
    tick(); redirect_valid = 1'b0; stall = 1'b0; #1;
    check("idle_redir_addr", 32'(imem_addr), 32'h200);

    // Two redirects while draining: the later target wins.
    tick(); imem_ack = 1'b0; redirect(12'h300, 12'h000); #1;
    check("drain2_addr", 32'(imem_addr), 32'h204);
    tick(); redirect(12'h400, 12'h010); #1;
    tick(); redirect_valid = 1'b0; imem_ack = 1'b1; #1;
    check("drain2_hold", 32'(imem_addr), 32'h204);
    tick(); #1;
    check("drain2_latest", 32'(imem_addr), 32'h410);

    // Misaligned target 0x022.
    tick(); redirect(12'h020, 12'h002); #1;
    tick(); redirect_valid = 1'b0; #1;
    if (TRAP_EN) begin
      check("trap_set", 32'(misalign_trap), 1);
      check("trap_halt_req", 32'(imem_req), 0);
    end else begin
      check("align_addr", 32'(imem_addr), 32'h020);
      check("align_no_trap", 32'(misalign_trap), 0);
    end
    tick(); #1;
    check("trap_sticky", 32'(misalign_trap), 32'(TRAP_EN));

    // Reset in the middle of an outstanding request.
    tick(); imem_ack = 1'b0;
    tick(); rst = 1'b0; #1;
    check("midrst_req", 32'(imem_req), 0);
    check("midrst_addr", 32'(imem_addr), 0);
    check("midrst_trap", 32'(misalign_trap), 0);
    tick(); rst = 1'b1; imem_ack = 1'b1; #1;
    check("rerun_idle", 32'(imem_req), 0);
    tick(); #1;
    check("rerun_req", 32'(imem_req), 1);
    tick(); #1;
    check("rerun_pc", 32'(instr_pc), 32'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
